// File: rtl/mem_stream_reader.sv
// Sweeps a word range out of a 1-cycle-latency RAM onto a valid/ready stream.
// A 4-entry FIFO with issue credits absorbs RAM latency and consumer stalls.
module mem_stream_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 26
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   issue_left;
  logic [ADDR_W:0]   beats_left;
  logic              v1, v2;
  logic [DATA_W-1:0] fifo [4];
  logic [1:0]        wr_idx, rd_idx;
  logic [2:0]        fifo_cnt;
  logic [3:0]        credit_use;
  logic [ADDR_W-1:0] base_c, issue_addr;
  logic [ADDR_W:0]   count_c;
  logic              accept, issue, push, pop;

  function automatic logic [ADDR_W-1:0] wrap_inc(
    input logic [ADDR_W-1:0] a
  );
    return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + ADDR_W'(1);
  endfunction

  assign base_c = (base_addr >= ADDR_W'(DEPTH)) ? '0 : base_addr;
  assign count_c = (count > (ADDR_W+1)'(DEPTH)) ?
                   (ADDR_W+1)'(DEPTH) : count;

  assign accept = (state == IDLE) && start;
  assign credit_use = {1'b0, fifo_cnt} + {3'b0, v1} + {3'b0, v2};
  assign issue = (accept && count_c != '0) ||
                 (state == READ && issue_left != '0 &&
                  credit_use < 4'd4);
  assign issue_addr = accept ? base_c : rd_ptr;

  assign m_valid = fifo_cnt != 3'd0;
  assign m_data  = fifo[rd_idx];
  assign m_last  = m_valid && beats_left == (ADDR_W+1)'(1);
  // RAM data is free-running; only the cycle tagged by v2 is captured
  assign push = v2;
  assign pop  = m_valid && m_ready;

  assign busy    = (state == READ) || (state == DRAIN);
  assign done    = (state == FIN);
  assign mem_we  = 1'b0;
  assign mem_din = '0;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = (count_c != '0) ? READ : FIN;
      READ:  if (issue_left == '0) state_nx = DRAIN;
      DRAIN: if (pop && m_last) state_nx = FIN;
      FIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      issue_left <= '0;
      beats_left <= '0;
      mem_addr   <= '0;
      v1         <= 1'b0;
      v2         <= 1'b0;
      wr_idx     <= '0;
      rd_idx     <= '0;
      fifo_cnt   <= '0;
      for (int i = 0; i < 4; i++) fifo[i] <= '0;
    end else begin
      state <= state_nx;
      v1    <= issue;
      v2    <= v1;
      if (accept) begin
        beats_left <= count_c;
        issue_left <= (count_c == '0) ? '0 :
                      count_c - (ADDR_W+1)'(1);
      end else begin
        if (issue) issue_left <= issue_left - (ADDR_W+1)'(1);
        if (pop) beats_left <= beats_left - (ADDR_W+1)'(1);
      end
      if (issue) begin
        mem_addr <= issue_addr;
        rd_ptr   <= wrap_inc(issue_addr);
      end
      if (push) begin
        fifo[wr_idx] <= mem_dout;
        wr_idx       <= wr_idx + 2'd1;
      end
      if (pop) rd_idx <= rd_idx + 2'd1;
      fifo_cnt <= fifo_cnt + {2'b0, push} - {2'b0, pop};
    end
  end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Randomized bench for mem_stream_reader with a queue-based reference model
// and a preloaded RAM model; one negedge process compares every cycle.
module tb_mem_stream_reader;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 26;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   count = '0;
  logic          busy, done, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout = '0;
  logic [DW-1:0] m_data;
  logic          m_valid, m_last;
  logic          m_ready = 1'b1;

  mem_stream_reader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .base_addr(base_addr), .count(count),
    .busy(busy), .done(done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
    .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [32];
  initial begin
    for (int i = 0; i < 32; i++)
      ram[i] = (i < DEPTH) ? 32'h100 + i : 32'hdead_0000 + i;
  end
  always @(posedge clk) mem_dout <= ram[mem_addr];

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // reference model state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  int phase = 0;
  int cyc = 0;
  int acc_cyc = -1;
  int first_cyc = -1;
  int last_cyc = -1;
  int done_cnt = 0;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic prev_last = 1'b0;

  function automatic int cl_base(input int b);
    return (b >= DEPTH) ? 0 : b;
  endfunction
  function automatic int cl_cnt(input int n);
    return (n > DEPTH) ? DEPTH : n;
  endfunction

  always @(negedge clk) begin
    int n, b;
    logic lx;
    cyc++;
    lx = 1'b0;
    if (!rst_n) begin
      chk("rst_ctl", {busy, done, m_valid, m_last}, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_data", m_data, 0);
      exp_q.delete();
      phase = 0;
      prev_stall = 1'b0;
    end else begin
      chk("busy", busy, phase == 1);
      chk("done", done, phase == 2);
      chk("mem_we", mem_we, 0);
      chk("mem_din", mem_din, 0);
      if (done) done_cnt++;
      if (prev_stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, prev_data);
        chk("stall_last", m_last, prev_last);
      end
      if (m_valid) begin
        if (exp_q.size() == 0) chk("extra_beat", m_valid, 0);
        else begin
          chk("data", m_data, exp_q[0]);
          chk("last", m_last, exp_q.size() == 1);
          if (first_cyc < 0) first_cyc = cyc;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
      if (m_valid && m_ready && exp_q.size() > 0) begin
        got_q.push_back(m_data);
        lx = exp_q.size() == 1;
        void'(exp_q.pop_front());
        if (lx) last_cyc = cyc;
      end
      case (phase)
        0: if (start) begin
          n = cl_cnt(int'(count));
          b = cl_base(int'(base_addr));
          for (int k = 0; k < n; k++)
            exp_q.push_back(32'h100 + DW'((b + k) % DEPTH));
          phase = (n == 0) ? 2 : 1;
          acc_cyc = cyc;
          first_cyc = -1;
        end
        1: if (lx) phase = 2;
        default: phase = 0;
      endcase
    end
  end

  int rmode = 0;
  int rcnt = 0;

  task automatic step();
    @(posedge clk);
    #1;
    case (rmode)
      0: m_ready = 1'b1;
      1: m_ready = 1'($urandom % 2);
      default: m_ready = (rcnt < 12) ? 1'b0 : ((rcnt - 12) % 2 == 0);
    endcase
    rcnt++;
  endtask

  task automatic go(input int b, input int n);
    got_q.delete();
    done_cnt = 0;
    rcnt = 0;
    start = 1'b1;
    base_addr = AW'(b);
    count = (AW+1)'(n);
    step();
    start = 1'b0;
    base_addr = AW'($urandom);
    count = (AW+1)'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    do begin
      step();
      k++;
    end while (phase != 0 && k < budget);
    chk("timeout", phase, 0);
  endtask

  task automatic chk_seq(input string name, input int b, input int n);
    chk({name, "_len"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++)
      chk(name, got_q[i], 32'h100 + (b + i) % DEPTH);
  endtask

  initial begin
    #100000000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1);
  end

  initial begin
    int b, n, k;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    rmode = 0;
    go(0, 26);
    wait_idle(200);
    chk_seq("full", 0, 26);
    chk("full_first", got_q[0], 32'h100);
    chk("full_lastw", got_q[25], 32'h119);
    chk("latency", first_cyc - acc_cyc, 3);
    chk("throughput", last_cyc - first_cyc, 25);
    chk("full_done", done_cnt, 1);

    go(24, 4);
    wait_idle(100);
    chk("wrap_len", got_q.size(), 4);
    chk("wrap0", got_q[0], 32'h118);
    chk("wrap1", got_q[1], 32'h119);
    chk("wrap2", got_q[2], 32'h100);
    chk("wrap3", got_q[3], 32'h101);

    rmode = 2;
    go(0, 10);
    wait_idle(200);
    chk_seq("bp", 0, 10);
    chk("bp_done", done_cnt, 1);

    rmode = 0;
    go(5, 0);
    wait_idle(20);
    chk("cnt0_done", done_cnt, 1);
    chk("cnt0_beats", got_q.size(), 0);

    go(0, 26);
    k = 0;
    while (got_q.size() < 5 && k < 100) begin
      step();
      k++;
    end
    chk("rst_wait", got_q.size(), 5);
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_nodone", done_cnt, 0);
    rst_n = 1'b1;
    step();
    go(3, 2);
    wait_idle(100);
    chk("post_rst0", got_q[0], 32'h103);
    chk("post_rst1", got_q[1], 32'h104);
    chk("post_rst_len", got_q.size(), 2);

    rmode = 1;
    go(2, 20);
    repeat (6) step();
    start = 1'b1;
    base_addr = 5'd9;
    count = 6'd3;
    step();
    start = 1'b0;
    wait_idle(300);
    chk_seq("restart", 2, 20);
    chk("restart_done", done_cnt, 1);

    for (int it = 0; it < 30; it++) begin
      rmode = int'($urandom % 2);
      b = int'($urandom % 32);
      n = int'($urandom % 40);
      go(b, n);
      wait_idle(400);
      chk("rnd_len", got_q.size(), cl_cnt(n));
      chk("rnd_done", done_cnt, 1);
      repeat (int'($urandom % 3)) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
